// File: rtl/fft_stage_sequencer_if.sv
// Control/status bundle for the radix-2, 64-point FFT stage sequencer.
//   mastertrig : start request from the input-sample counter (to sequencer)
//   en         : advance enable; low freezes the sequencer (to sequencer)
//   stage      : current butterfly stage 0..5
//   addr_a/b   : upper/lower-leg working-memory addresses
//   tw_addr    : twiddle ROM address
//   bf_valid   : addr_a/addr_b/tw_addr valid this cycle
//   out_addr   : bit-reversed unload read address
//   out_valid  : out_addr valid this cycle
//   busy       : sequencer not idle
//   done       : one-cycle frame-complete pulse
//   overrun    : one-cycle pulse for a start request seen while busy
// The master modport is the controlling side; the slave modport is the sequencer.
interface fft_stage_sequencer_if;
  logic       mastertrig;
  logic       en;
  logic [2:0] stage;
  logic [5:0] addr_a;
  logic [5:0] addr_b;
  logic [4:0] tw_addr;
  logic       bf_valid;
  logic [5:0] out_addr;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output mastertrig, en,
    input  stage, addr_a, addr_b, tw_addr, bf_valid,
    input  out_addr, out_valid, busy, done, overrun
  );

  modport slave (
    input  mastertrig, en,
    output stage, addr_a, addr_b, tw_addr, bf_valid,
    output out_addr, out_valid, busy, done, overrun
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 64-point FFT.
// Runs 6 stages of 32 butterflies, waits BF_LAT cycles after each stage for
// the butterfly pipeline to drain, then unloads 64 results in bit-reversed
// order and pulses done.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of fft_stage_sequencer_if (trigger/enable in,
//          addresses, valids and status out)
// All outputs are registered: each register holds what is presented in the
// current cycle, and an enabled edge advances to the next item.
module fft_stage_sequencer #(
  parameter int unsigned BF_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_stage_sequencer_if.slave  bus
);

  localparam logic [2:0] LAT = 3'(BF_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD,
    S_FINISH
  } state_t;

  state_t     state_q;
  logic [2:0] stage_q;
  logic [4:0] j_q;
  logic [5:0] k_q;
  logic [2:0] dcnt_q;
  logic [5:0] addr_a_q;
  logic [5:0] addr_b_q;
  logic [4:0] tw_q;
  logic       bf_valid_q;
  logic [5:0] out_addr_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       overrun_q;

  // Butterfly addressing: {addr_a, addr_b, tw_addr} for stage s, index j.
  function automatic logic [16:0] bf_addr(input logic [2:0] s, input logic [4:0] j);
    logic [5:0] mask;
    logic [5:0] pos;
    logic [5:0] grp;
    logic [5:0] a;
    logic [5:0] b;
    logic [4:0] tw;
    mask = (6'd1 << s) - 6'd1;
    pos  = {1'b0, j} & mask;
    grp  = {1'b0, j} >> s;
    a    = (grp << (s + 3'd1)) | pos;
    b    = a + (6'd1 << s);
    tw   = pos[4:0] << (3'd5 - s);
    return {a, b, tw};
  endfunction

  function automatic logic [5:0] bitrev(input logic [5:0] v);
    logic [5:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      r[i] = v[5 - i];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_q        <= '0;
      bf_valid_q  <= 1'b0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // FINISH counts as busy, so a trigger coincident with done is an overrun.
      overrun_q   <= bus.en && bus.mastertrig && (state_q != S_IDLE);
      bf_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.mastertrig) begin
              state_q                        <= S_COMPUTE;
              stage_q                        <= '0;
              j_q                            <= '0;
              {addr_a_q, addr_b_q, tw_q}     <= bf_addr(3'd0, 5'd0);
              bf_valid_q                     <= 1'b1;
              busy_q                         <= 1'b1;
            end
          end
          S_COMPUTE: begin
            if (j_q == 5'd31) begin
              state_q <= S_DRAIN;
              j_q     <= '0;
              dcnt_q  <= 3'd1;
            end else begin
              j_q                        <= j_q + 5'd1;
              {addr_a_q, addr_b_q, tw_q} <= bf_addr(stage_q, j_q + 5'd1);
              bf_valid_q                 <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (dcnt_q == LAT) begin
              if (stage_q != 3'd5) begin
                state_q                    <= S_COMPUTE;
                stage_q                    <= stage_q + 3'd1;
                {addr_a_q, addr_b_q, tw_q} <= bf_addr(stage_q + 3'd1, 5'd0);
                bf_valid_q                 <= 1'b1;
              end else begin
                state_q     <= S_UNLOAD;
                k_q         <= '0;
                out_addr_q  <= '0;
                out_valid_q <= 1'b1;
              end
            end else begin
              dcnt_q <= dcnt_q + 3'd1;
            end
          end
          S_UNLOAD: begin
            if (k_q == 6'd63) begin
              state_q <= S_FINISH;
              k_q     <= '0;
              done_q  <= 1'b1;
            end else begin
              k_q         <= k_q + 6'd1;
              out_addr_q  <= bitrev(k_q + 6'd1);
              out_valid_q <= 1'b1;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            stage_q <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            stage_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stage     = stage_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_b    = addr_b_q;
  assign bus.tw_addr   = tw_q;
  assign bus.bf_valid  = bf_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (BF_LAT = 3).
// Cycle numbering: cycle 0 is the cycle in which mastertrig is high; cycle n
// is the interval following the n-th rising edge after it.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_sequencer_if bus();

  fft_stage_sequencer #(.BF_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int          cyc;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t tab [NV];

  // Frame statistics gathered by run_frame.
  int          cyc;
  int          done_cyc;
  int          done_cnt;
  int          ov_cnt;
  int          ov_c [2];
  int          outv_cnt;
  int          bfv_cnt;
  int          overlap;
  logic        busy_end;
  logic [31:0] snap5, snap9, snap10;
  int          idle_bad;

  function automatic logic [31:0] pk(input logic [2:0] st, input logic [5:0] a,
                                     input logic [5:0] b, input logic [4:0] tw,
                                     input logic bv, input logic ov,
                                     input logic [5:0] oa, input logic by,
                                     input logic dn, input logic ovr);
    return {1'b0, st, a, b, tw, bv, ov, oa, by, dn, ovr};
  endfunction

  function automatic logic [31:0] cur();
    return pk(bus.stage, bus.addr_a, bus.addr_b, bus.tw_addr, bus.bf_valid,
              bus.out_valid, bus.out_addr, bus.busy, bus.done, bus.overrun);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit use_tab, input int stall_at, input int trig_a,
                           input int trig_b, input int rst_at);
    done_cyc = -1; done_cnt = 0; ov_cnt = 0; ov_c[0] = -1; ov_c[1] = -1;
    outv_cnt = 0; bfv_cnt = 0; overlap = 0; busy_end = 1'bx;
    snap5 = '0; snap9 = '0; snap10 = '0;
    bus.en = 1'b1;
    bus.mastertrig = 1'b1;
    step();
    bus.mastertrig = 1'b0;
    cyc = 1;
    while (cyc <= 700) begin
      if (use_tab) begin
        for (int i = 0; i < NV; i++) begin
          if (tab[i].cyc == cyc) chk($sformatf("vec_cyc%0d", cyc), cur(), tab[i].exp);
        end
      end
      if (bus.bf_valid && bus.out_valid) overlap++;
      if (bus.out_valid) outv_cnt++;
      if (bus.bf_valid) bfv_cnt++;
      if (bus.overrun) begin
        if (ov_cnt < 2) ov_c[ov_cnt] = cyc;
        ov_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 5) snap5 = cur();
      if (cyc == 9) snap9 = cur();
      if (cyc == 10) snap10 = cur();
      if (cyc == rst_at) begin
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", cur(), '0);
        step();
        step();
        rst = 1'b1;
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        busy_end = bus.busy;
        break;
      end
      bus.en = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      bus.mastertrig = (cyc == trig_a) || (cyc == trig_b);
      step();
      cyc++;
    end
    bus.en = 1'b1;
    bus.mastertrig = 1'b0;
  endtask

  initial begin
    // Nominal frame expectations: {cycle, stage, a, b, tw, bf_v, out_v, out_addr, busy, done, overrun}
    tab[0]  = '{1,   pk(3'd0, 6'd0,  6'd1,  5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[1]  = '{2,   pk(3'd0, 6'd2,  6'd3,  5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[2]  = '{3,   pk(3'd0, 6'd4,  6'd5,  5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[3]  = '{4,   pk(3'd0, 6'd6,  6'd7,  5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[4]  = '{33,  pk(3'd0, 6'd62, 6'd63, 5'd0,  1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[5]  = '{36,  pk(3'd1, 6'd0,  6'd2,  5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[6]  = '{37,  pk(3'd1, 6'd1,  6'd3,  5'd16, 1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[7]  = '{115, pk(3'd3, 6'd17, 6'd25, 5'd4,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[8]  = '{176, pk(3'd5, 6'd0,  6'd32, 5'd0,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[9]  = '{177, pk(3'd5, 6'd1,  6'd33, 5'd1,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[10] = '{207, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[11] = '{208, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[12] = '{211, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b1, 6'd0,  1'b1, 1'b0, 1'b0)};
    tab[13] = '{212, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b1, 6'd32, 1'b1, 1'b0, 1'b0)};
    tab[14] = '{213, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b1, 6'd16, 1'b1, 1'b0, 1'b0)};
    tab[15] = '{214, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b1, 6'd48, 1'b1, 1'b0, 1'b0)};
    tab[16] = '{274, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0, 1'b0)};
    tab[17] = '{275, pk(3'd5, 6'd31, 6'd63, 5'd31, 1'b0, 1'b0, 6'd63, 1'b1, 1'b1, 1'b0)};
    tab[18] = '{276, pk(3'd0, 6'd31, 6'd63, 5'd31, 1'b0, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0)};

    rst = 1'b0;
    bus.en = 1'b1;
    bus.mastertrig = 1'b0;
    step();
    step();
    chk("reset_state_held", cur(), '0);
    rst = 1'b1;
    step();
    chk("reset_state_released", cur(), '0);

    // Frame 1: nominal timing and addressing.
    run_frame(1'b1, -1, -1, -1, -1);
    chk("f1_done_cycle", done_cyc, 275);
    chk("f1_done_count", done_cnt, 1);
    chk("f1_out_valid_count", outv_cnt, 64);
    chk("f1_bf_valid_count", bfv_cnt, 192);
    chk("f1_valid_overlap", overlap, 0);
    chk("f1_overrun_count", ov_cnt, 0);

    // Frame 2: en low for 5 cycles after stage 0, j=3 is presented.
    run_frame(1'b0, 4, -1, -1, -1);
    chk("f2_freeze_first", snap5, pk(3'd0, 6'd6, 6'd7, 5'd0, 1'b0, 1'b0, 6'd63, 1'b1, 1'b0, 1'b0));
    chk("f2_freeze_last", snap9, pk(3'd0, 6'd6, 6'd7, 5'd0, 1'b0, 1'b0, 6'd63, 1'b1, 1'b0, 1'b0));
    chk("f2_resume_j4", snap10, pk(3'd0, 6'd8, 6'd9, 5'd0, 1'b1, 1'b0, 6'd63, 1'b1, 1'b0, 1'b0));
    chk("f2_done_cycle", done_cyc, 280);
    chk("f2_out_valid_count", outv_cnt, 64);
    chk("f2_bf_valid_count", bfv_cnt, 192);

    // Frame 3: triggers during DRAIN and during the done cycle.
    run_frame(1'b0, -1, 33, 275, -1);
    chk("f3_overrun_count", ov_cnt, 2);
    chk("f3_overrun_drain_cycle", ov_c[0], 34);
    chk("f3_overrun_done_cycle", ov_c[1], 276);
    chk("f3_done_cycle", done_cyc, 275);
    chk("f3_no_restart_busy", {31'd0, busy_end}, 32'd0);
    chk("f3_bf_valid_count", bfv_cnt, 192);

    // Frame 4: reset asserted mid-unload (k=19).
    run_frame(1'b0, -1, -1, -1, 230);
    chk("f4_done_count", done_cnt, 0);
    chk("f4_out_valid_before_reset", outv_cnt, 20);
    idle_bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done || bus.busy || bus.bf_valid || bus.out_valid) idle_bad++;
      step();
    end
    chk("f4_idle_after_reset", idle_bad, 0);

    // Frame 5: full frame after the aborted one.
    run_frame(1'b0, -1, -1, -1, -1);
    chk("f5_done_cycle", done_cyc, 275);
    chk("f5_done_count", done_cnt, 1);
    chk("f5_out_valid_count", outv_cnt, 64);
    chk("f5_valid_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 The block SHALL have parameter BF_LAT, default 3, meaning butterfly datapath latency in cycles (legal 1..7).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port mastertrig  input  1  single-cycle start request from the input-sample counter.
REQ-005 The block SHALL have port en  input  1  advance enable; low freezes all state and counters.
REQ-006 The block SHALL have port stage  output  3  current butterfly stage, 0..5.
REQ-007 The block SHALL have port addr_a  output  6  upper-leg working-memory address.
REQ-008 The block SHALL have port addr_b  output  6  lower-leg working-memory address.
REQ-009 The block SHALL have port tw_addr  output  5  twiddle ROM address.
REQ-010 The block SHALL have port bf_valid  output  1  addr_a, addr_b and tw_addr are valid this cycle.
REQ-011 The block SHALL have port out_addr  output  6  bit-reversed read address during unload.
REQ-012 The block SHALL have port out_valid  output  1  out_addr is valid this cycle.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse when the frame is complete.
REQ-015 The block SHALL have port overrun  output  1  one-cycle pulse on mastertrig received while busy.

Function
REQ-016 The block SHALL implement states IDLE, COMPUTE, DRAIN, UNLOAD and FINISH; all outputs SHALL be registered.
REQ-017 IDLE: on mastertrig=1 with en=1, the block SHALL go to COMPUTE with stage=0 and butterfly index j=0; otherwise it SHALL stay in IDLE.
REQ-018 COMPUTE: each enabled cycle, the block SHALL issue butterfly j (0..31) with bf_valid=1 and then increment j.
- pos = j mod 2^stage; grp = j >> stage.
- addr_a = grp*2^(stage+1) + pos; addr_b = addr_a + 2^stage.
- tw_addr = pos << (5 - stage).
- Arithmetic SHALL be 6-bit unsigned with no wrap beyond 63.
REQ-019 After j=31 is issued, the block SHALL go to DRAIN with j reset to 0.
REQ-020 DRAIN: bf_valid SHALL be 0 for exactly BF_LAT enabled cycles. Then, if stage<5, stage SHALL increment and the block SHALL return to COMPUTE; if stage=5, it SHALL go to UNLOAD with stage unchanged.
REQ-021 UNLOAD: for unload count k = 0..63, one per enabled cycle, the block SHALL drive out_valid=1 and out_addr = bit-reverse(k), i.e. out_addr[i] = k[5-i]. After k=63, it SHALL go to FINISH.
REQ-022 FINISH: the block SHALL assert done=1 for one cycle, go to IDLE, and return stage to 0.
REQ-023 Frame length SHALL be 6*(32+BF_LAT) + 64 + 1 enabled cycles from the start cycle to the done cycle.
REQ-024 With en=0, the block SHALL hold state, j, k and stage, and SHALL force bf_valid, out_valid, done and overrun to 0; address outputs SHALL hold their values.
REQ-025 mastertrig while busy SHALL be ignored for sequencing and SHALL produce overrun=1 in the following cycle, unless en=0 in that cycle.
REQ-026 mastertrig arriving in the same cycle as done SHALL be treated as busy (overrun); a restart SHALL only be accepted from IDLE.
REQ-027 bf_valid and out_valid SHALL never be high in the same cycle.

Reset
REQ-028 rst=0 SHALL immediately and asynchronously force IDLE, stage=0, j=0, k=0, addr_a=0, addr_b=0, tw_addr=0, out_addr=0, and bf_valid=out_valid=busy=done=overrun=0.
REQ-029 Reset deassertion mid-frame SHALL leave the block in IDLE awaiting a new mastertrig; the aborted frame SHALL produce no done pulse.

Verification
REQ-030 The bench SHALL apply reset, then mastertrig with en=1 and BF_LAT=3, and check: stage0 j=0..3 gives addr_a/addr_b 0/1, 2/3, 4/5, 6/7 with tw_addr=0; busy=1; done at cycle 6*35+65=275 after start.
REQ-031 The bench SHALL check stage 5 of the same frame: j=0 gives 0/32 with tw=0; j=1 gives 1/33 with tw=1; j=31 gives 31/63 with tw=31; stage 3 j=9 gives addr_a=17, addr_b=25, tw_addr=4.
REQ-032 The bench SHALL check unload: k=0,1,2,3,63 gives out_addr 0, 32, 16, 48, 63; out_valid is high for exactly 64 cycles and is never overlapped with bf_valid.
REQ-033 The bench SHALL hold en=0 for 5 cycles mid-COMPUTE and check that the outputs freeze, the valids are 0, and done is delayed by exactly 5 cycles.
REQ-034 The bench SHALL pulse mastertrig during DRAIN and during the done cycle and check that overrun pulses once each and frame timing is unchanged.
REQ-035 The bench SHALL drive rst=0 during UNLOAD and check that all outputs are 0 asynchronously with no done pulse, and that a new mastertrig after release runs a full frame.
